// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
//   state_t    : FSM encoding (IDLE, CALC, DONE)
//   N_W_DEF    : default dividend/quotient width
//   D_W_DEF    : default divisor/remainder width
//   CNT_W      : bit-counter width for the default dividend width
//   cnt_width(): counter width for an arbitrary dividend width (min 1)
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int N_W_DEF = 8;
  localparam int D_W_DEF = 4;
  localparam int CNT_W   = $clog2(N_W_DEF);

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_restoring_divider_if.sv
// Handshake/data bundle for the sequential restoring divider.
//   master : operand producer / result consumer
//            drives in_valid, dividend, divisor, out_ready
//   slave  : the divider
//            drives in_ready, out_valid, quotient, remainder, div_by_zero, busy
interface seq_restoring_divider_if
  import div_pkg::*;
#(
  parameter int N_W = N_W_DEF,
  parameter int D_W = D_W_DEF
);

  logic           in_valid;
  logic           in_ready;
  logic [N_W-1:0] dividend;
  logic [D_W-1:0] divisor;
  logic           out_valid;
  logic           out_ready;
  logic [N_W-1:0] quotient;
  logic [D_W-1:0] remainder;
  logic           div_by_zero;
  logic           busy;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero, busy
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero, busy
  );

endinterface

// File: rtl/div_step.sv
// One radix-2 restoring division step (purely combinational).
//   r_in    : current partial remainder (always < divisor)
//   bit_in  : next dividend bit, MSB first
//   divisor : divisor (non-zero when used)
//   r_out   : partial remainder after this step
//   q_bit   : quotient bit produced by this step
module div_step #(
  parameter int D_W = 4
) (
  input  logic [D_W-1:0] r_in,
  input  logic           bit_in,
  input  logic [D_W-1:0] divisor,
  output logic [D_W-1:0] r_out,
  output logic           q_bit
);

  // The shifted remainder needs one extra bit; after a subtract it is again
  // below the divisor, so D_W bits are enough to carry it to the next step.
  logic [D_W:0] r_sh;

  always_comb begin
    r_sh  = {r_in, bit_in};
    q_bit = (r_sh >= {1'b0, divisor});
    if (q_bit) begin
      r_out = D_W'(r_sh - {1'b0, divisor});
    end else begin
      r_out = r_sh[D_W-1:0];
    end
  end

endmodule

// File: rtl/seq_restoring_divider.sv
// Iterative radix-2 restoring divider, one quotient bit per clock.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : slave side of seq_restoring_divider_if
//          in_valid/in_ready  - operand handshake, operands sampled on accept
//          out_valid/out_ready- result handshake, result held until accepted
//          quotient/remainder - registered result
//          div_by_zero        - result came from a zero divisor
//          busy               - high while calculating or holding a result
// Latency: out_valid rises N_W edges after the accept edge (the accept edge
// itself for a zero divisor).
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int N_W = N_W_DEF,
  parameter int D_W = D_W_DEF
) (
  input logic                    clk,
  input logic                    rst,
  seq_restoring_divider_if.slave bus
);

  localparam int CW = cnt_width(N_W);

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [D_W-1:0] r_acc;
  logic [N_W-1:0] dvd_q;
  logic [D_W-1:0] dvs_q;
  logic [N_W-1:0] q_work;

  logic           in_ready_q;
  logic           out_valid_q;
  logic           busy_q;
  logic [N_W-1:0] quotient_q;
  logic [D_W-1:0] remainder_q;
  logic           dbz_q;

  logic [D_W-1:0] r_step;
  logic           q_bit;
  logic [N_W-1:0] q_next;

  div_step #(.D_W(D_W)) u_step (
    .r_in    (r_acc),
    .bit_in  (dvd_q[cnt]),
    .divisor (dvs_q),
    .r_out   (r_step),
    .q_bit   (q_bit)
  );

  // Working quotient with the current step's bit merged in; on the last step
  // this is the final quotient, so it can be published on the same edge.
  always_comb begin
    q_next      = q_work;
    q_next[cnt] = q_bit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      r_acc       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      q_work      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            dvd_q      <= bus.dividend;
            dvs_q      <= bus.divisor;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (bus.divisor == '0) begin
              // Zero divisor: no iteration, report saturated quotient.
              state       <= DONE;
              out_valid_q <= 1'b1;
              quotient_q  <= '1;
              remainder_q <= '0;
              dbz_q       <= 1'b1;
            end else begin
              state  <= CALC;
              r_acc  <= '0;
              cnt    <= CW'(N_W - 1);
              q_work <= '0;
              dbz_q  <= 1'b0;
            end
          end
        end

        CALC: begin
          r_acc  <= r_step;
          q_work <= q_next;
          if (cnt == '0) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
            quotient_q  <= q_next;
            remainder_q <= r_step;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end

        default: begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.busy        = busy_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider (8-bit / 4-bit defaults).
module tb_seq_restoring_divider;

  localparam int N_W = 8;
  localparam int D_W = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  seq_restoring_divider_if #(.N_W(N_W), .D_W(D_W)) bus ();

  seq_restoring_divider #(.N_W(N_W), .D_W(D_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] n;
    logic [3:0] d;
    logic [7:0] q;
    logic [3:0] r;
    logic       dbz;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: present operands, wait for accept, wait for the
  // result, optionally stall the handshake, then accept the result.
  task automatic run_op(input logic [7:0] n, input logic [3:0] d, input int stall,
                        output logic [7:0] q, output logic [3:0] r, output logic dbz,
                        output int lat, output bit to);
    int k;
    bus.dividend = n;
    bus.divisor  = d;
    bus.in_valid = 1'b1;
    k = 0;
    while (!bus.in_ready && k < 40) begin
      tick();
      k++;
    end
    tick();
    bus.in_valid = 1'b0;
    bus.dividend = ~n;
    bus.divisor  = ~d;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      tick();
      lat++;
    end
    to  = !bus.out_valid;
    q   = bus.quotient;
    r   = bus.remainder;
    dbz = bus.div_by_zero;
    repeat (stall) tick();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q;
    logic [3:0] r;
    logic       dbz;
    int         lat;
    int         k;
    bit         to;
    bit         ok;

    vecs[0]  = '{8'd200, 4'd7,  8'd28,  4'd4, 1'b0};
    vecs[1]  = '{8'd255, 4'd15, 8'd17,  4'd0, 1'b0};
    vecs[2]  = '{8'd5,   4'd9,  8'd0,   4'd5, 1'b0};
    vecs[3]  = '{8'h3C,  4'd0,  8'hFF,  4'd0, 1'b1};
    vecs[4]  = '{8'h3C,  4'd3,  8'd20,  4'd0, 1'b0};
    vecs[5]  = '{8'd100, 4'd3,  8'd33,  4'd1, 1'b0};
    vecs[6]  = '{8'd250, 4'd6,  8'd41,  4'd4, 1'b0};
    vecs[7]  = '{8'd0,   4'd5,  8'd0,   4'd0, 1'b0};
    vecs[8]  = '{8'd255, 4'd1,  8'd255, 4'd0, 1'b0};
    vecs[9]  = '{8'd1,   4'd15, 8'd0,   4'd1, 1'b0};
    vecs[10] = '{8'd171, 4'd13, 8'd13,  4'd2, 1'b0};
    vecs[11] = '{8'd0,   4'd0,  8'hFF,  4'd0, 1'b1};
    vecs[12] = '{8'd143, 4'd11, 8'd13,  4'd0, 1'b0};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    repeat (2) tick();

    // Reset state
    chk("rst_in_ready",  bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy",      bus.busy, 0);
    chk("rst_quotient",  bus.quotient, 0);
    chk("rst_remainder", bus.remainder, 0);
    chk("rst_dbz",       bus.div_by_zero, 0);
    rst = 1'b0;
    tick();

    // Directed table
    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].n, vecs[i].d, i % 3, q, r, dbz, lat, to);
      chk($sformatf("vec%0d_timeout", i), to, 0);
      chk($sformatf("vec%0d_quotient", i), q, vecs[i].q);
      chk($sformatf("vec%0d_remainder", i), r, vecs[i].r);
      chk($sformatf("vec%0d_dbz", i), dbz, vecs[i].dbz);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].dbz ? 0 : N_W);
    end

    // 200/7 with busy/in_ready tracked through every calculation cycle
    bus.dividend = 8'd200;
    bus.divisor  = 4'd7;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < N_W; i++) begin
      chk($sformatf("calc%0d_busy", i), bus.busy, 1);
      chk($sformatf("calc%0d_out_valid", i), bus.out_valid, 0);
      chk($sformatf("calc%0d_in_ready", i), bus.in_ready, 0);
      tick();
    end
    chk("calc_done_valid", bus.out_valid, 1);
    chk("calc_done_busy", bus.busy, 1);
    chk("calc_done_q", bus.quotient, 28);
    chk("calc_done_r", bus.remainder, 4);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("calc_after_busy", bus.busy, 0);
    chk("calc_after_in_ready", bus.in_ready, 1);

    // Back-to-back: 255/15 then 5/9 with out_ready held high
    bus.out_ready = 1'b1;
    bus.dividend  = 8'd255;
    bus.divisor   = 4'd15;
    bus.in_valid  = 1'b1;
    tick();
    bus.dividend = 8'd5;
    bus.divisor  = 4'd9;
    k = 0;
    while (!bus.out_valid && k < 40) begin
      tick();
      k++;
    end
    chk("b2b_lat1", k, N_W);
    chk("b2b_q1", bus.quotient, 17);
    chk("b2b_r1", bus.remainder, 0);
    tick();
    chk("b2b_idle_in_ready", bus.in_ready, 1);
    chk("b2b_idle_out_valid", bus.out_valid, 0);
    tick();
    chk("b2b_accept2", bus.in_ready, 0);
    bus.in_valid = 1'b0;
    k = 2;
    while (!bus.out_valid && k < 50) begin
      tick();
      k++;
    end
    chk("b2b_gap", k, N_W + 2);
    chk("b2b_q2", bus.quotient, 0);
    chk("b2b_r2", bus.remainder, 5);
    tick();
    bus.out_ready = 1'b0;
    chk("b2b_end_in_ready", bus.in_ready, 1);

    // Backpressure: 100/3 held for 5 cycles while in_valid pulses
    bus.dividend = 8'd100;
    bus.divisor  = 4'd3;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    k = 0;
    while (!bus.out_valid && k < 40) begin
      tick();
      k++;
    end
    chk("bp_lat", k, N_W);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = (i % 2 == 0);
      bus.dividend = 8'd7;
      bus.divisor  = 4'd2;
      tick();
      chk($sformatf("bp%0d_out_valid", i), bus.out_valid, 1);
      chk($sformatf("bp%0d_q", i), bus.quotient, 33);
      chk($sformatf("bp%0d_r", i), bus.remainder, 1);
      chk($sformatf("bp%0d_in_ready", i), bus.in_ready, 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("bp_hs_out_valid", bus.out_valid, 0);
    chk("bp_hs_in_ready", bus.in_ready, 1);
    tick();
    chk("bp_no_accept_busy", bus.busy, 0);
    chk("bp_no_accept_in_ready", bus.in_ready, 1);
    chk("bp_hold_q", bus.quotient, 33);

    // Reset in the middle of a calculation
    bus.dividend = 8'd250;
    bus.divisor  = 4'd6;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (4) tick();
    chk("mid_busy_before_rst", bus.busy, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready",  bus.in_ready, 1);
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_busy",      bus.busy, 0);
    chk("mid_rst_quotient",  bus.quotient, 0);
    chk("mid_rst_remainder", bus.remainder, 0);
    chk("mid_rst_dbz",       bus.div_by_zero, 0);
    tick();
    rst = 1'b0;
    repeat (10) tick();
    chk("mid_no_stale_valid", bus.out_valid, 0);
    chk("mid_idle_in_ready", bus.in_ready, 1);
    run_op(8'd250, 4'd6, 0, q, r, dbz, lat, to);
    chk("mid_rerun_timeout", to, 0);
    chk("mid_rerun_q", q, 41);
    chk("mid_rerun_r", r, 4);
    chk("mid_rerun_lat", lat, N_W);

    // Exhaustive sweep with random result stalls
    for (int n = 0; n < 256; n++) begin
      for (int d = 0; d < 16; d++) begin
        run_op(8'(n), 4'(d), int'($urandom_range(0, 2)), q, r, dbz, lat, to);
        if (d == 0) begin
          ok = !to && dbz == 1'b1 && q == 8'hFF && r == 4'd0 && lat == 0;
        end else begin
          ok = !to && dbz == 1'b0 && (int'(q) * d + int'(r) == n) &&
               (int'(r) < d) && lat == N_W;
        end
        checks++;
        if (!ok) begin
          errors++;
          $display("FAIL sweep %0d/%0d: got q=%0d r=%0d dbz=%0d lat=%0d timeout=%0d",
                   n, d, q, r, dbz, lat, to);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
